// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier accumulator back end.
package booth_pkg;

    // Width of the signed product delivered by the Booth multiplier.
    localparam int unsigned PROD_W = 16;

    // Default accumulator and term-counter widths.
    localparam int unsigned ACC_W_DEF = 24;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/booth_acc_add.sv
// Combinational signed add of a sign-extended product into the accumulator.
// Detects signed overflow; with BOOTH_ACC_SAT_EN defined the result clamps to
// the signed limit in the direction of the addend, otherwise it wraps.
module booth_acc_add
    import booth_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] raw;

    // Sign-extend the product, add, and flag overflow from the operand/result signs.
    always_comb begin
        addend = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        raw    = acc + addend;
        ovf    = (acc[ACC_W-1] == addend[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
`ifdef BOOTH_ACC_SAT_EN
        if (ovf) begin
            // Both operands share a sign on overflow, so the addend sign picks the limit.
            sum = addend[ACC_W-1] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                  : {1'b0, {(ACC_W - 1){1'b1}}};
        end else begin
            sum = raw;
        end
`else
        sum = raw;
`endif
    end

endmodule

// File: rtl/booth_acc.sv
// Signed multiply-accumulate back end for the 8x8 radix-4 Booth multiplier.
// Sums a programmed number of 16-bit products into an ACC_W-bit accumulator
// and strobes acc_valid for one cycle when the run completes.
// Optional saturation: define BOOTH_ACC_SAT_EN (see booth_acc_add).
module booth_acc
    import booth_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_terms,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    output logic              busy,
    output logic              ovf
);

    acc_state_t       state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;

    booth_acc_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc  (acc_q),
        .prod (prod),
        .sum  (add_sum),
        .ovf  (add_ovf)
    );

    // State, counter and accumulator registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
        end
    end

    // Next-state logic: start only counts in IDLE; DONE lasts a single cycle.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = num_terms;
                    acc_d       = '0;
                    ovf_d       = 1'b0;
                    state_d     = (num_terms == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                // prod_ready is high throughout ACCUM, so valid alone means accept.
                if (prod_valid) begin
                    acc_d       = add_sum;
                    ovf_d       = ovf_q | add_ovf;
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode the registered state only.
    always_comb begin
        prod_ready = (state_q == ACCUM);
        acc_valid  = (state_q == DONE);
        busy       = (state_q != IDLE);
        acc_out    = acc_q;
        ovf        = ovf_q;
    end

endmodule
